// File: rtl/uart_tx_arbiter.sv
// Round-robin arbiter in front of the UART tx FIFO: one requester owns the byte
// stream for a whole message, released on its last byte or after a stall timeout.
module uart_tx_arbiter #(
  parameter int         NUM_REQ      = 4,
  parameter logic [7:0] IDLE_TIMEOUT = 8'd255
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 enable,
  input  logic [NUM_REQ-1:0]   req_valid,
  input  logic [NUM_REQ-1:0]   req_last,
  input  logic [8*NUM_REQ-1:0] req_data,
  output logic [NUM_REQ-1:0]   req_ready,
  output logic                 out_valid,
  output logic [7:0]           out_data,
  input  logic                 out_ready,
  output logic [2:0]           grant_id,
  output logic                 busy,
  output logic                 timeout_pulse
);
  typedef enum logic {S_IDLE = 1'b0, S_GRANT = 1'b1} state_t;

  state_t     r_state;
  logic [2:0] r_grant;
  logic [2:0] r_rr_last;
  logic [7:0] r_stall;
  logic       r_timeout;

  logic       w_active;
  logic       w_own_valid;
  logic       w_own_last;
  logic [7:0] w_own_data;
  logic       w_xfer;
  logic       w_found;
  logic [2:0] w_next;
  int         w_idx;

  // Gating with rst keeps every output quiet during the reset cycle itself.
  assign w_active = (r_state == S_GRANT) && !rst;

  always_comb begin
    w_own_valid = 1'b0;
    w_own_last  = 1'b0;
    w_own_data  = 8'h00;
    req_ready   = '0;
    for (int i = 0; i < NUM_REQ; i++) begin
      if (r_grant == 3'(i)) begin
        w_own_valid  = req_valid[i];
        w_own_last   = req_last[i];
        w_own_data   = req_data[8*i +: 8];
        req_ready[i] = w_active && out_ready;
      end
    end
  end

  // Search starts just past the previous owner so a finished owner goes to the back.
  always_comb begin
    w_found = 1'b0;
    w_next  = 3'd0;
    w_idx   = 0;
    for (int k = 1; k <= NUM_REQ; k++) begin
      w_idx = int'(r_rr_last) + k;
      if (w_idx >= NUM_REQ) w_idx = w_idx - NUM_REQ;
      for (int j = 0; j < NUM_REQ; j++) begin
        if (!w_found && (w_idx == j) && req_valid[j]) begin
          w_found = 1'b1;
          w_next  = 3'(j);
        end
      end
    end
  end

  assign out_valid     = w_active && w_own_valid;
  assign out_data      = w_active ? w_own_data : 8'h00;
  assign w_xfer        = out_valid && out_ready;
  assign busy          = w_active;
  assign grant_id      = rst ? 3'd0 : r_grant;
  assign timeout_pulse = r_timeout && !rst;

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state   <= S_IDLE;
      r_grant   <= 3'd0;
      r_rr_last <= 3'(NUM_REQ - 1);
      r_stall   <= 8'd0;
      r_timeout <= 1'b0;
    end else begin
      r_timeout <= 1'b0;
      case (r_state)
        S_IDLE: begin
          if (enable && w_found) begin
            r_state <= S_GRANT;
            r_grant <= w_next;
            r_stall <= 8'd0;
          end
        end
        S_GRANT: begin
          // A completing last byte wins over a timeout in the same cycle.
          if (w_xfer && w_own_last) begin
            r_state   <= S_IDLE;
            r_rr_last <= r_grant;
            r_grant   <= 3'd0;
            r_stall   <= 8'd0;
          end else if (w_own_valid) begin
            r_stall <= 8'd0;
          end else if (r_stall == IDLE_TIMEOUT - 8'd1) begin
            r_state   <= S_IDLE;
            r_rr_last <= r_grant;
            r_grant   <= 3'd0;
            r_stall   <= 8'd0;
            r_timeout <= 1'b1;
          end else begin
            r_stall <= r_stall + 8'd1;
          end
        end
        default: r_state <= S_IDLE;
      endcase
    end
  end
endmodule

// File: tb/tb_uart_tx_arbiter.sv
// Directed bench for uart_tx_arbiter: table of per-cycle vectors plus
// hand-written multi-cycle sequences (backpressure, timeout, enable, reset).
module tb_uart_tx_arbiter;
  logic        clk;
  logic        rst;
  logic        enable;
  logic [3:0]  req_valid;
  logic [3:0]  req_last;
  logic [31:0] req_data;
  logic [3:0]  req_ready;
  logic        out_valid;
  logic [7:0]  out_data;
  logic        out_ready;
  logic [2:0]  grant_id;
  logic        busy;
  logic        timeout_pulse;

  int n_tests = 0;
  int n_fail  = 0;

  uart_tx_arbiter #(.NUM_REQ(4), .IDLE_TIMEOUT(8'd16)) dut (
    .clk(clk), .rst(rst), .enable(enable),
    .req_valid(req_valid), .req_last(req_last), .req_data(req_data),
    .req_ready(req_ready), .out_valid(out_valid), .out_data(out_data),
    .out_ready(out_ready), .grant_id(grant_id), .busy(busy),
    .timeout_pulse(timeout_pulse)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #100000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  typedef struct {
    logic       rst;
    logic       en;
    logic [3:0] vld;
    logic [3:0] lst;
    logic       ordy;
    logic [2:0] gid;
    logic       bsy;
    logic       ov;
    logic [3:0] rdy;
    logic [7:0] od;
    logic       to;
  } vec_t;

  vec_t tbl[23];

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h, expected %0h", name, act, exp);
    end
  endtask

  initial begin
    int   cnt;
    int   guard;
    int   n;
    int   bad;
    logic seen;
    logic [7:0] exp_b [5];

    //           rst en  vld      lst      ordy gid  bsy ov  rdy      od     to
    tbl[0]  = '{1'b1,1'b1,4'b1010,4'b0000,1'b1,3'd0,1'b0,1'b0,4'b0000,8'h00,1'b0};
    tbl[1]  = '{1'b0,1'b1,4'b1010,4'b0000,1'b1,3'd0,1'b0,1'b0,4'b0000,8'h00,1'b0};
    tbl[2]  = '{1'b0,1'b1,4'b1010,4'b0000,1'b1,3'd1,1'b1,1'b1,4'b0010,8'hA1,1'b0};
    tbl[3]  = '{1'b0,1'b1,4'b1010,4'b0010,1'b1,3'd1,1'b1,1'b1,4'b0010,8'hA1,1'b0};
    tbl[4]  = '{1'b0,1'b1,4'b1010,4'b0000,1'b1,3'd0,1'b0,1'b0,4'b0000,8'h00,1'b0};
    tbl[5]  = '{1'b0,1'b1,4'b1010,4'b1000,1'b1,3'd3,1'b1,1'b1,4'b1000,8'hA3,1'b0};
    tbl[6]  = '{1'b0,1'b1,4'b0000,4'b0000,1'b1,3'd0,1'b0,1'b0,4'b0000,8'h00,1'b0};
    tbl[7]  = '{1'b0,1'b1,4'b1111,4'b1111,1'b1,3'd0,1'b0,1'b0,4'b0000,8'h00,1'b0};
    tbl[8]  = '{1'b0,1'b1,4'b1111,4'b1111,1'b1,3'd0,1'b1,1'b1,4'b0001,8'hA0,1'b0};
    tbl[9]  = '{1'b0,1'b1,4'b1111,4'b1111,1'b1,3'd0,1'b0,1'b0,4'b0000,8'h00,1'b0};
    tbl[10] = '{1'b0,1'b1,4'b1111,4'b1111,1'b1,3'd1,1'b1,1'b1,4'b0010,8'hA1,1'b0};
    tbl[11] = '{1'b0,1'b1,4'b1111,4'b1111,1'b1,3'd0,1'b0,1'b0,4'b0000,8'h00,1'b0};
    tbl[12] = '{1'b0,1'b1,4'b1111,4'b1111,1'b1,3'd2,1'b1,1'b1,4'b0100,8'hA2,1'b0};
    tbl[13] = '{1'b0,1'b1,4'b1111,4'b1111,1'b1,3'd0,1'b0,1'b0,4'b0000,8'h00,1'b0};
    tbl[14] = '{1'b0,1'b1,4'b1111,4'b1111,1'b1,3'd3,1'b1,1'b1,4'b1000,8'hA3,1'b0};
    tbl[15] = '{1'b0,1'b1,4'b1111,4'b1111,1'b1,3'd0,1'b0,1'b0,4'b0000,8'h00,1'b0};
    tbl[16] = '{1'b0,1'b1,4'b1111,4'b1111,1'b1,3'd0,1'b1,1'b1,4'b0001,8'hA0,1'b0};
    tbl[17] = '{1'b0,1'b1,4'b0000,4'b0000,1'b1,3'd0,1'b0,1'b0,4'b0000,8'h00,1'b0};
    tbl[18] = '{1'b0,1'b1,4'b0100,4'b0100,1'b1,3'd0,1'b0,1'b0,4'b0000,8'h00,1'b0};
    tbl[19] = '{1'b0,1'b1,4'b0000,4'b0100,1'b1,3'd2,1'b1,1'b0,4'b0100,8'hA2,1'b0};
    tbl[20] = '{1'b0,1'b1,4'b0100,4'b1111,1'b0,3'd2,1'b1,1'b1,4'b0000,8'hA2,1'b0};
    tbl[21] = '{1'b0,1'b1,4'b0100,4'b0100,1'b1,3'd2,1'b1,1'b1,4'b0100,8'hA2,1'b0};
    tbl[22] = '{1'b0,1'b1,4'b0000,4'b0000,1'b1,3'd0,1'b0,1'b0,4'b0000,8'h00,1'b0};

    rst = 1'b1; enable = 1'b1; req_valid = '0; req_last = '0;
    req_data = 32'hA3A2A1A0; out_ready = 1'b1;
    tick();
    tick();

    for (int i = 0; i < 23; i++) begin
      rst = tbl[i].rst; enable = tbl[i].en; req_valid = tbl[i].vld;
      req_last = tbl[i].lst; out_ready = tbl[i].ordy;
      #1;
      chk($sformatf("row%0d grant_id", i), 32'(grant_id), 32'(tbl[i].gid));
      chk($sformatf("row%0d busy", i), 32'(busy), 32'(tbl[i].bsy));
      chk($sformatf("row%0d out_valid", i), 32'(out_valid), 32'(tbl[i].ov));
      chk($sformatf("row%0d req_ready", i), 32'(req_ready), 32'(tbl[i].rdy));
      chk($sformatf("row%0d out_data", i), 32'(out_data), 32'(tbl[i].od));
      chk($sformatf("row%0d timeout", i), 32'(timeout_pulse), 32'(tbl[i].to));
      tick();
    end

    // Port 2, 5-byte message with 300 cycles of backpressure after byte 3.
    exp_b[0] = 8'h10; exp_b[1] = 8'h11; exp_b[2] = 8'h12; exp_b[3] = 8'h13; exp_b[4] = 8'h14;
    req_data = 32'h33EE0011;
    req_valid = 4'b0100; req_last = 4'b0000; out_ready = 1'b1;
    cnt = 0; guard = 0;
    while (cnt < 3 && guard < 10) begin
      req_data[23:16] = exp_b[cnt];
      #1;
      if (out_valid && out_ready && req_ready[2]) begin
        chk($sformatf("bp byte%0d", cnt), 32'(out_data), 32'(exp_b[cnt]));
        cnt++;
      end
      guard++;
      tick();
    end
    out_ready = 1'b0; req_data[23:16] = exp_b[3]; bad = 0;
    for (int c = 0; c < 300; c++) begin
      #1;
      if (timeout_pulse || !busy || req_ready != 4'b0000 || !out_valid) bad++;
      tick();
    end
    chk("bp hold no timeout", 32'(bad), 32'd0);
    out_ready = 1'b1; guard = 0;
    while (cnt < 5 && guard < 10) begin
      req_data[23:16] = exp_b[cnt];
      req_last = (cnt == 4) ? 4'b0100 : 4'b0000;
      #1;
      if (out_valid && out_ready && req_ready[2]) begin
        chk($sformatf("bp byte%0d", cnt), 32'(out_data), 32'(exp_b[cnt]));
        cnt++;
      end
      guard++;
      tick();
    end
    chk("bp byte count", 32'(cnt), 32'd5);
    req_valid = 4'b0000; req_last = 4'b0000;
    #1;
    chk("bp released", 32'(busy), 32'd0);
    tick();

    // Port 0 stalls after 2 bytes; release after IDLE_TIMEOUT=16 cycles, then port 1.
    req_data = 32'h00006655;
    req_valid = 4'b0011; req_last = 4'b0000; out_ready = 1'b1;
    cnt = 0; guard = 0;
    while (cnt < 2 && guard < 10) begin
      #1;
      if (out_valid && req_ready[0]) begin
        chk($sformatf("to owner byte%0d", cnt), 32'(out_data), 32'h55);
        cnt++;
      end
      guard++;
      tick();
    end
    chk("to bytes sent", 32'(cnt), 32'd2);
    req_valid = 4'b0010;
    n = 0; seen = 1'b0;
    while (n < 40) begin
      #1;
      if (timeout_pulse) begin
        seen = 1'b1;
        break;
      end
      n++;
      tick();
    end
    chk("to pulse seen", 32'(seen), 32'd1);
    chk("to stall cycles", 32'(n), 32'd16);
    chk("to busy on pulse", 32'(busy), 32'd0);
    tick();
    #1;
    chk("to next grant", 32'(grant_id), 32'd1);
    chk("to next busy", 32'(busy), 32'd1);
    chk("to pulse one cycle", 32'(timeout_pulse), 32'd0);
    req_last = 4'b0010;
    tick();
    req_valid = 4'b0000; req_last = 4'b0000;
    tick();

    // enable=0 mid-message on port 3: message completes, no new grant until enable=1.
    req_data = 32'h7700_0088;
    req_valid = 4'b1000; enable = 1'b1;
    tick();
    enable = 1'b0; req_valid = 4'b1001;
    #1;
    chk("en grant", 32'(grant_id), 32'd3);
    chk("en byte0 accepted", 32'({out_valid, req_ready}), 32'b1_1000);
    tick();
    req_last = 4'b1000;
    #1;
    chk("en last byte", 32'({out_valid, out_data}), 32'h177);
    tick();
    req_valid = 4'b0001; req_last = 4'b0001; bad = 0;
    for (int c = 0; c < 5; c++) begin
      #1;
      if (busy) bad++;
      tick();
    end
    chk("en blocked", 32'(bad), 32'd0);
    enable = 1'b1;
    tick();
    #1;
    chk("en regrant id", 32'(grant_id), 32'd0);
    chk("en regrant busy", 32'(busy), 32'd1);
    tick();
    req_valid = 4'b0000; req_last = 4'b0000;
    tick();

    // Reset mid-message on port 2 with port 1 also waiting.
    req_data = 32'h0099_5500;
    req_valid = 4'b0100;
    tick();
    req_valid = 4'b0110;
    #1;
    chk("rst pre grant", 32'(grant_id), 32'd2);
    tick();
    rst = 1'b1;
    #1;
    chk("rst out_valid", 32'(out_valid), 32'd0);
    chk("rst req_ready", 32'(req_ready), 32'd0);
    chk("rst busy/grant", 32'({busy, grant_id}), 32'd0);
    tick();
    rst = 1'b0;
    #1;
    chk("rst after idle", 32'({busy, out_valid, req_ready}), 32'd0);
    tick();
    #1;
    chk("rst first grant", 32'(grant_id), 32'd1);
    chk("rst first busy", 32'(busy), 32'd1);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end
endmodule
